// File: rtl/if_id_stage.sv
// IF/ID pipeline register: two-entry skid buffer (main M + skid S) with valid/ready
// handshakes, flush, and MIPS field split. Optional perf counters via `IFID_PERF_CNT_EN.
module if_id_stage #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_pc_plus4,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm16,
  output logic [25:0]     out_target26
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic            m_valid;
  logic [31:0]     m_instr;
  logic [PC_W-1:0] m_pc;
  logic            s_valid;
  logic [31:0]     s_instr;
  logic [PC_W-1:0] s_pc;

  logic accept;
  logic m_free;

  // in_ready comes straight from the skid flop, so decode backpressure never
  // reaches fetch combinationally.
  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign m_free   = ~m_valid | out_ready;

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, which the M<-S move depends on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_instr <= NOP_INSTR;
      m_pc    <= '0;
      s_valid <= 1'b0;
      s_instr <= '0;
      s_pc    <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_instr <= NOP_INSTR;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_instr <= s_instr;
        m_pc    <= s_pc;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_instr <= in_instr;
        m_pc    <= in_pc;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_instr <= in_instr;
      s_pc    <= in_pc;
    end
  end

  assign out_valid    = m_valid;
  assign out_instr    = m_instr;
  assign out_pc       = m_pc;
  assign out_pc_plus4 = m_pc + PC_W'(4);

  // Field slices stay live while out_valid=0; decode qualifies them.
  assign out_opcode   = m_instr[31:26];
  assign out_rs       = m_instr[25:21];
  assign out_rt       = m_instr[20:16];
  assign out_rd       = m_instr[15:11];
  assign out_shamt    = m_instr[10:6];
  assign out_funct    = m_instr[5:0];
  assign out_imm16    = m_instr[15:0];
  assign out_target26 = m_instr[25:0];

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_valid & ~out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-to-decode pipeline stage for the MIPS core.
- Registers a fetched instruction and its PC behind a two-entry skid buffer with valid/ready handshakes.
- Splits the instruction into R/I/J fields. The 16-bit immediate output drives the sign extender directly.
- Supports decode-side backpressure without a combinational ready path, plus a flush for taken branches/jumps.

Parameters:
- PC_W, 32, width of program counter fields.
- NOP_INSTR, 32'h0000_0000, instruction word loaded into the output register on reset/flush.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  address of in_instr.
- flush  input  1  discard all held and incoming instructions this cycle.
- out_valid  output  1  decode-side data valid.
- out_ready  input  1  decode accepts this cycle.
- out_instr  output  32  held instruction.
- out_pc  output  PC_W  held PC.
- out_pc_plus4  output  PC_W  out_pc + 4, modulo 2^PC_W.
- out_opcode  output  6  out_instr[31:26].
- out_rs  output  5  out_instr[25:21].
- out_rt  output  5  out_instr[20:16].
- out_rd  output  5  out_instr[15:11].
- out_shamt  output  5  out_instr[10:6].
- out_funct  output  6  out_instr[5:0].
- out_imm16  output  16  out_instr[15:0], to sign extender.
- out_target26  output  26  out_instr[25:0].

Behaviour:
- Storage:
  - Main register M (instr, pc, valid) drives all out_* fields.
  - Skid register S (instr, pc, valid).
- Reset (async, rst=1):
  - M.valid=0, S.valid=0, M.instr=NOP_INSTR, M.pc=0, S cleared.
  - Outputs: out_valid=0, in_ready=1, out_pc_plus4=4, all field outputs = slices of NOP_INSTR.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - in_ready = !S.valid, registered.
- Per rising edge, no flush:
  - M empty or consumed, S empty: accepted input → M; otherwise M.valid=0, M data holds.
  - M empty or consumed, S full: S → M, S.valid=0. No input accepted, since in_ready=0.
  - M full and not consumed, input accepted: input → S, S.valid=1, in_ready drops next cycle.
  - M full and not consumed, nothing accepted: hold.
- Latency:
  - One cycle from acceptance to out_valid when the path is empty.
  - Full throughput (one instruction/cycle) while out_ready=1.
- Flush:
  - Highest priority.
  - On the edge with flush=1: M.valid=0, S.valid=0, M.instr=NOP_INSTR; M.pc keeps its previous value.
  - Any input handshaking in the flush cycle is dropped.
  - in_ready=1 on the following cycle.
- Ordering: strict FIFO order. S always holds the younger instruction than M.
- Fields: purely combinational slices of M.instr. They remain defined (stale data) when out_valid=0; consumers qualify them with out_valid.
- Simultaneous consume + accept with S empty: input → M in the same edge, no bubble.
- Reset mid-operation: both entries lost immediately, with no dependence on clk.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]:
  - stall_cnt increments each cycle out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both counters wrap at 2^32 and reset to 0 on rst.
- When undefined: ports absent, no counter logic.

Test Plan:
- Reset then idle:
  - Response: out_valid=0, in_ready=1, out_pc_plus4=32'h4.
  - After rst deasserts, one accept of instr=32'h2008FFFF, pc=32'h00400000 → next cycle: out_valid=1, out_opcode=6'h08, out_rs=0, out_rt=8, out_imm16=16'hFFFF, out_pc_plus4=32'h00400004.
- Streaming, out_ready=1:
  - Stimulus: 4 back-to-back instructions at pc 0x0, 0x4, 0x8, 0xC.
  - Response: emerged in order on consecutive cycles, in_ready constantly 1.
- Backpressure:
  - Stimulus: out_ready=0 while 3 instructions are offered.
  - Response: first → M, second → S, in_ready=0 next cycle, third held off.
  - Then out_ready=1: sequence drains in order with no loss or duplication.
- Flush:
  - Stimulus: with M and S full, assert flush while in_valid=1 with instr=32'h0C000010.
  - Response: next cycle out_valid=0, in_ready=1, out_instr=32'h0; flushed instructions never appear.
- Async reset mid-stream:
  - Stimulus: pulse rst between clock edges while out_valid=1.
  - Response: out_valid=0 immediately, before the next edge.
- Perf counters (IFID_PERF_CNT_EN):
  - Stimulus: 5 stall cycles, then 2 flush cycles.
  - Response: stall_cnt=5, flush_cnt=2.
